topo_stream_gen: RTL and testbench

- Upstream feeder for the day11 path-count stage: DFS from a start node over a CSR adjacency graph in external synchronous RAMs.
- Emits nodes in post-order (every child before its parent) as a 32-bit word stream: header word then child-index words.
- Downstream stage consumes the stream directly over valid/ready and accumulates path counts in a single pass.

---
 rtl/day11_pkg.sv | 43 ++++
 rtl/topo_stack.sv | 59 +++++
 rtl/topo_stream_gen.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_topo_stream_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/day11_pkg.sv
// Shared types for the day11 topological stream generator.
// Holds node/count widths, stream header field positions, the header
// packing helper, the traversal FSM state encoding and the DFS stack entry.
package day11_pkg;

    localparam int unsigned NODE_W       = 16;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned HDR_NODE_LSB = 16;
    localparam int unsigned HDR_CNT_LSB  = 0;

    typedef logic [NODE_W-1:0] node_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_SCAN,
        ST_CHECK,
        ST_EMIT_HDR,
        ST_EMIT_CHILD,
        ST_POP,
        ST_DONE
    } state_e;

    typedef struct packed {
        node_t node;
        cnt_t  base;
        cnt_t  count;
        cnt_t  next_child;
    } stack_entry_t;

    // Header word: node index in the upper field, raw edge count in the lower.
    function automatic logic [WORD_W-1:0] pack_hdr(input node_t node, input cnt_t count);
        logic [WORD_W-1:0] w;
        w = '0;
        w[HDR_NODE_LSB +: NODE_W] = node;
        w[HDR_CNT_LSB  +: CNT_W]  = count;
        return w;
    endfunction

endpackage

// File: rtl/topo_stack.sv
// LIFO holding the DFS path.
// Ports: flush/push/pop act on the pointer; upd rewrites the top entry in place.
// top_c is the current top entry, full_c/empty_c/level_c decode the pointer.
// Only the pointer is reset; entry storage is plain RAM.
module topo_stack #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned W     = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         upd,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 top_c,
    output logic                         full_c,
    output logic                         empty_c,
    output logic [$clog2(DEPTH+1)-1:0]   level_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [IDX_W-1:0] top_idx;

    assign top_idx = IDX_W'(ptr_q - PTR_W'(1));
    assign top_c   = mem[top_idx];
    assign full_c  = (ptr_q == PTR_W'(DEPTH));
    assign empty_c = (ptr_q == '0);
    assign level_c = ptr_q;

    // Pointer: flush wins, pushes into a full stack are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (flush) begin
            ptr_q <= '0;
        end else if (push && !full_c) begin
            ptr_q <= ptr_q + PTR_W'(1);
        end else if (pop && !empty_c) begin
            ptr_q <= ptr_q - PTR_W'(1);
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push && !full_c) begin
                mem[IDX_W'(ptr_q)] <= din;
            end else if (upd && !empty_c) begin
                mem[top_idx] <= din;
            end
        end
    end

endmodule

// File: rtl/topo_stream_gen.sv
// DFS post-order stream generator over a CSR graph held in external sync RAMs.
// Every reachable node is emitted once as a header {node, edge_count} followed
// by its child indices; children always precede their parent.
// Ports: start/start_node launch a traversal; tbl_* and edge_* are the node
// table and edge RAM read ports (1-cycle latency); out_* is the valid/ready
// word stream (out_last on the root's final word); busy/done/error report status.
// Optional build macro TOPO_CYCLE_CHECK_EN: flag back edges (cycles) as errors.
module topo_stream_gen #(
    parameter int unsigned NUM_NODES   = 1024,
    parameter int unsigned NODE_W      = 16,
    parameter int unsigned STACK_DEPTH = 256,
    parameter int unsigned EDGE_AW     = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NODE_W-1:0]  start_node,
    output logic [NODE_W-1:0]  tbl_addr,
    input  logic [31:0]        tbl_rdata,
    output logic [EDGE_AW-1:0] edge_addr,
    input  logic [NODE_W-1:0]  edge_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               error
);

    import day11_pkg::*;

    localparam int unsigned NUM_WORDS = (NUM_NODES + 31) / 32;
    localparam int unsigned WORD_AW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned PTR_W     = $clog2(STACK_DEPTH + 1);
    localparam int unsigned ENT_W     = $bits(stack_entry_t);

    function automatic logic [WORD_AW-1:0] word_of(input logic [NODE_W-1:0] n);
        return WORD_AW'(n >> 5);
    endfunction

    function automatic logic [4:0] bit_of(input logic [NODE_W-1:0] n);
        return n[4:0];
    endfunction

    state_e              state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic [NODE_W-1:0]   root_q, root_d;
    logic [WORD_AW-1:0]  clr_idx_q, clr_idx_d;
    cnt_t                emit_idx_q, emit_idx_d;

    logic [NODE_W-1:0]   tbl_addr_d;
    logic [EDGE_AW-1:0]  edge_addr_d;
    logic                out_valid_d, out_last_d;
    logic [31:0]         out_data_d;
    logic                busy_d, done_d, error_d;

    logic                stk_flush, stk_push, stk_pop, stk_upd;
    stack_entry_t        stk_din, top_e;
    logic [ENT_W-1:0]    stk_top;
    logic                stk_full, stk_empty;
    logic [PTR_W-1:0]    stk_level;

    logic                vis_clr, vis_set;
    logic [NODE_W-1:0]   vis_node;
    logic [31:0]         vis_mem [NUM_WORDS];

    logic hs, root_bad, at_root, scan_end, last_child;
    logic child_bad, child_vis, child_onstk;

    topo_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ENT_W)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (stk_flush),
        .push    (stk_push),
        .pop     (stk_pop),
        .upd     (stk_upd),
        .din     (stk_din),
        .top_c   (stk_top),
        .full_c  (stk_full),
        .empty_c (stk_empty),
        .level_c (stk_level)
    );

    assign top_e      = stk_top;
    assign hs         = out_valid && out_ready;
    assign root_bad   = (32'(start_node) >= NUM_NODES);
    assign at_root    = (stk_level == PTR_W'(1));
    assign scan_end   = (top_e.next_child == top_e.count);
    assign last_child = ((emit_idx_q + cnt_t'(1)) == top_e.count);
    // Out-of-range child indices are treated as corrupt graph data.
    assign child_bad  = (32'(edge_rdata) >= NUM_NODES);
    assign child_vis  = vis_mem[word_of(edge_rdata)][bit_of(edge_rdata)];

    // Visited bitmap: cleared word by word in CLEAR, never reset.
    // A set in the final CLEAR cycle lands after that word's clear.
    always_ff @(posedge clk) begin
        if (vis_clr) vis_mem[clr_idx_q] <= '0;
        if (vis_set) vis_mem[word_of(vis_node)][bit_of(vis_node)] <= 1'b1;
    end

`ifdef TOPO_CYCLE_CHECK_EN
    logic [31:0] onstk_mem [NUM_WORDS];

    // On-path bitmap: a visited child still on the path is a back edge.
    always_ff @(posedge clk) begin
        if (vis_clr) onstk_mem[clr_idx_q] <= '0;
        if (vis_set) onstk_mem[word_of(vis_node)][bit_of(vis_node)] <= 1'b1;
        if (stk_pop) onstk_mem[word_of(top_e.node)][bit_of(top_e.node)] <= 1'b0;
    end

    assign child_onstk = onstk_mem[word_of(edge_rdata)][bit_of(edge_rdata)];
`else
    assign child_onstk = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic. RAM reads use phase 0 (address in flight) and 1 (data valid).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = root_bad ? ST_DONE : ST_CLEAR;
            end
            ST_CLEAR: begin
                if (clr_idx_q == WORD_AW'(NUM_WORDS - 1)) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (phase_q == 2'd1) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                state_d = scan_end ? ST_EMIT_HDR : ST_CHECK;
            end
            ST_CHECK: begin
                if (phase_q == 2'd1) begin
                    if (child_bad || child_onstk) state_d = ST_DONE;
                    else if (child_vis)           state_d = ST_SCAN;
                    else if (stk_full)            state_d = ST_DONE;
                    else                          state_d = ST_FETCH;
                end
            end
            ST_EMIT_HDR: begin
                if (hs) state_d = (top_e.count == '0) ? ST_POP : ST_EMIT_CHILD;
            end
            ST_EMIT_CHILD: begin
                if (phase_q == 2'd2 && hs && last_child) state_d = ST_POP;
            end
            ST_POP: begin
                state_d = (at_root || stk_empty) ? ST_DONE : ST_SCAN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath decode: next values of all registered outputs plus strobes.
    always_comb begin
        phase_d     = phase_q;
        root_d      = root_q;
        clr_idx_d   = clr_idx_q;
        emit_idx_d  = emit_idx_q;
        tbl_addr_d  = tbl_addr;
        edge_addr_d = edge_addr;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_last_d  = out_last;
        busy_d      = busy;
        done_d      = done;
        error_d     = error;
        stk_flush   = 1'b0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_upd     = 1'b0;
        stk_din     = '0;
        vis_clr     = 1'b0;
        vis_set     = 1'b0;
        vis_node    = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    stk_flush = 1'b1;
                    done_d    = root_bad;
                    error_d   = root_bad;
                    busy_d    = !root_bad;
                    root_d    = start_node;
                    clr_idx_d = '0;
                end
            end
            ST_CLEAR: begin
                vis_clr   = 1'b1;
                clr_idx_d = clr_idx_q + WORD_AW'(1);
                if (clr_idx_q == WORD_AW'(NUM_WORDS - 1)) begin
                    stk_push     = 1'b1;
                    stk_din.node = node_t'(root_q);
                    vis_set      = 1'b1;
                    vis_node     = root_q;
                    tbl_addr_d   = root_q;
                    phase_d      = 2'd0;
                end
            end
            ST_FETCH: begin
                if (phase_q == 2'd0) begin
                    phase_d = 2'd1;
                end else begin
                    stk_upd            = 1'b1;
                    stk_din            = top_e;
                    stk_din.base       = tbl_rdata[31:16];
                    stk_din.count      = tbl_rdata[15:0];
                    stk_din.next_child = '0;
                    phase_d            = 2'd0;
                end
            end
            ST_SCAN: begin
                if (scan_end) begin
                    out_valid_d = 1'b1;
                    out_data_d  = pack_hdr(top_e.node, top_e.count);
                    out_last_d  = at_root && (top_e.count == '0);
                end else begin
                    edge_addr_d        = EDGE_AW'(top_e.base + top_e.next_child);
                    stk_upd            = 1'b1;
                    stk_din            = top_e;
                    stk_din.next_child = top_e.next_child + cnt_t'(1);
                    phase_d            = 2'd0;
                end
            end
            ST_CHECK: begin
                if (phase_q == 2'd0) begin
                    phase_d = 2'd1;
                end else begin
                    phase_d = 2'd0;
                    if (child_bad || child_onstk || (!child_vis && stk_full)) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else if (!child_vis) begin
                        stk_push     = 1'b1;
                        stk_din.node = node_t'(edge_rdata);
                        vis_set      = 1'b1;
                        vis_node     = edge_rdata;
                        tbl_addr_d   = edge_rdata;
                    end
                end
            end
            ST_EMIT_HDR: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    emit_idx_d  = '0;
                    edge_addr_d = EDGE_AW'(top_e.base);
                    phase_d     = 2'd0;
                end
            end
            ST_EMIT_CHILD: begin
                // Each child word is re-read then latched, so stalls never
                // expose a stale RAM output.
                case (phase_q)
                    2'd0: phase_d = 2'd1;
                    2'd1: begin
                        out_valid_d = 1'b1;
                        out_data_d  = 32'(edge_rdata);
                        out_last_d  = at_root && last_child;
                        phase_d     = 2'd2;
                    end
                    default: begin
                        if (hs) begin
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            phase_d     = 2'd0;
                            if (!last_child) begin
                                emit_idx_d  = emit_idx_q + cnt_t'(1);
                                edge_addr_d = EDGE_AW'(top_e.base + emit_idx_q + cnt_t'(1));
                            end
                        end
                    end
                endcase
            end
            ST_POP: begin
                stk_pop = 1'b1;
                phase_d = 2'd0;
                if (at_root || stk_empty) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= '0;
            root_q     <= '0;
            clr_idx_q  <= '0;
            emit_idx_q <= '0;
            tbl_addr   <= '0;
            edge_addr  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            root_q     <= root_d;
            clr_idx_q  <= clr_idx_d;
            emit_idx_q <= emit_idx_d;
            tbl_addr   <= tbl_addr_d;
            edge_addr  <= edge_addr_d;
            out_valid  <= out_valid_d;
            out_data   <= out_data_d;
            out_last   <= out_last_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
        end
    end

endmodule

// File: tb/tb_topo_stream_gen.sv
// Scoreboard bench for topo_stream_gen: expected {last, word} entries are queued
// when a traversal is launched and popped on every output handshake.
module tb_topo_stream_gen;

    logic        clk, rst_n, start, out_ready;
    logic [15:0] start_node, tbl_addr, edge_rdata;
    logic [31:0] tbl_rdata, out_data;
    logic [11:0] edge_addr;
    logic        out_valid, out_last, busy, done, error;

    logic        s_start;
    logic [15:0] s_tbl_addr, s_edge_rdata;
    logic [31:0] s_tbl_rdata, s_out_data;
    logic [11:0] s_edge_addr;
    logic        s_out_valid, s_out_last, s_busy, s_done, s_error;

    logic [31:0] tbl_mem  [1024];
    logic [15:0] edge_mem [4096];
    logic [63:0] sb [$];

    int n_checks = 0;
    int n_err    = 0;
    int hs_count = 0;
    int s_words  = 0;
    int rdy_mode = 0;
    int hold_cnt = 0;
    bit held     = 0;
    bit prev_stall = 0;
    logic [31:0] prev_data;
    logic        prev_last;

    topo_stream_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_node (start_node),
        .tbl_addr   (tbl_addr),
        .tbl_rdata  (tbl_rdata),
        .edge_addr  (edge_addr),
        .edge_rdata (edge_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    topo_stream_gen #(.STACK_DEPTH(4)) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (s_start),
        .start_node (16'd0),
        .tbl_addr   (s_tbl_addr),
        .tbl_rdata  (s_tbl_rdata),
        .edge_addr  (s_edge_addr),
        .edge_rdata (s_edge_rdata),
        .out_valid  (s_out_valid),
        .out_ready  (1'b1),
        .out_data   (s_out_data),
        .out_last   (s_out_last),
        .busy       (s_busy),
        .done       (s_done),
        .error      (s_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM models, one cycle read latency.
    always @(posedge clk) begin
        tbl_rdata    <= tbl_mem[tbl_addr[9:0]];
        edge_rdata   <= edge_mem[edge_addr];
        s_tbl_rdata  <= tbl_mem[s_tbl_addr[9:0]];
        s_edge_rdata <= edge_mem[s_edge_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic exp_word(input logic [31:0] d, input logic l);
        sb.push_back({31'b0, l, d});
    endtask

    task automatic clear_graph();
        for (int i = 0; i < 1024; i++) tbl_mem[i] = '0;
        for (int i = 0; i < 4096; i++) edge_mem[i] = '0;
    endtask

    task automatic set_node(input int n, input int base, input int cnt);
        tbl_mem[n] = {16'(base), 16'(cnt)};
    endtask

    // Ready driver: always-ready, or random with one 7-cycle hold on the third word.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                out_ready = 1'b1;
            end else if (hold_cnt > 0) begin
                out_ready = 1'b0;
                hold_cnt--;
            end else if (!held && out_valid && hs_count == 2) begin
                held      = 1;
                hold_cnt  = 6;
                out_ready = 1'b0;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Output monitor: scoreboard pop on handshake, stability across stalls.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (prev_stall)
                    chk("stall_hold", {30'b0, out_valid, out_last, out_data},
                        {30'b0, 1'b1, prev_last, prev_data});
                if (out_valid && out_ready) begin
                    hs_count++;
                    if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'(1));
                    else chk("word", {31'b0, out_last, out_data}, sb.pop_front());
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
                if (s_out_valid) s_words++;
            end
        end
    end

    task automatic run_case(input string name, input logic [15:0] root,
                            input logic exp_err, input bit poke);
        int cyc;
        hs_count = 0;
        held     = 0;
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_node = root;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, "_busy_start"}, 64'(busy), 64'(root < 16'd1024));
        cyc = 0;
        while (!done && cyc < 5000) begin
            if (poke && cyc == 10) begin
                start      = 1'b1;
                start_node = 16'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        chk({name, "_done"}, 64'(done), 64'(1));
        chk({name, "_error"}, 64'(error), 64'(exp_err));
        chk({name, "_busy_end"}, 64'(busy), 64'(0));
        chk({name, "_sb_left"}, 64'(sb.size()), 64'(0));
        sb.delete();
    endtask

    task automatic load_chain();
        clear_graph();
        set_node(0, 10, 1); edge_mem[10] = 16'd1;
        set_node(1, 11, 1); edge_mem[11] = 16'd2;
        set_node(2, 12, 0);
    endtask

    task automatic push_chain();
        exp_word(32'h0002_0000, 1'b0);
        exp_word(32'h0001_0001, 1'b0);
        exp_word(32'h0000_0002, 1'b0);
        exp_word(32'h0000_0001, 1'b0);
        exp_word(32'h0000_0001, 1'b1);
    endtask

    // Node 0's edge list straddles the end of edge RAM to exercise address wrap.
    task automatic load_diamond();
        clear_graph();
        set_node(0, 4095, 2); edge_mem[4095] = 16'd1; edge_mem[0] = 16'd2;
        set_node(1, 1, 1);    edge_mem[1] = 16'd3;
        set_node(2, 2, 1);    edge_mem[2] = 16'd3;
        set_node(3, 3, 0);
    endtask

    task automatic push_diamond();
        exp_word(32'h0003_0000, 1'b0);
        exp_word(32'h0001_0001, 1'b0);
        exp_word(32'h0000_0003, 1'b0);
        exp_word(32'h0002_0001, 1'b0);
        exp_word(32'h0000_0003, 1'b0);
        exp_word(32'h0000_0002, 1'b0);
        exp_word(32'h0000_0001, 1'b0);
        exp_word(32'h0000_0002, 1'b1);
    endtask

    initial begin
        int cyc;
        rst_n      = 1'b0;
        start      = 1'b0;
        s_start    = 1'b0;
        start_node = '0;
        clear_graph();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", {36'b0, tbl_addr, edge_addr}, 64'(0));
        chk("rst_outs", {26'b0, out_valid, out_last, busy, done, error, out_data}, 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        load_chain();
        push_chain();
        run_case("chain", 16'd0, 1'b0, 1'b1);

        rdy_mode = 1;
        push_chain();
        run_case("chain_bp", 16'd0, 1'b0, 1'b0);
        chk("bp_hold_seen", 64'(held), 64'(1));
        rdy_mode = 0;

        load_diamond();
        push_diamond();
        run_case("diamond", 16'd0, 1'b0, 1'b0);

        exp_word(32'h0003_0000, 1'b0);
        exp_word(32'h0001_0001, 1'b0);
        exp_word(32'h0000_0003, 1'b1);
        run_case("diamond_r1", 16'd1, 1'b0, 1'b0);

        run_case("bad_root", 16'd1024, 1'b1, 1'b0);
        chk("bad_root_words", 64'(hs_count), 64'(0));

        clear_graph();
        for (int i = 0; i < 5; i++) begin
            set_node(i, 100 + i, 1);
            edge_mem[100 + i] = 16'(i + 1);
        end
        set_node(5, 105, 0);
        @(posedge clk);
        #1;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        cyc = 0;
        while (!s_done && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("ovf_done", 64'(s_done), 64'(1));
        chk("ovf_error", 64'(s_error), 64'(1));
        chk("ovf_busy", 64'(s_busy), 64'(0));
        chk("ovf_words", 64'(s_words), 64'(0));

        clear_graph();
        set_node(0, 20, 1); edge_mem[20] = 16'd1;
        set_node(1, 21, 1); edge_mem[21] = 16'd0;
`ifdef TOPO_CYCLE_CHECK_EN
        run_case("cycle", 16'd0, 1'b1, 1'b0);
        chk("cycle_words", 64'(hs_count), 64'(0));
`else
        exp_word(32'h0001_0001, 1'b0);
        exp_word(32'h0000_0000, 1'b0);
        exp_word(32'h0000_0001, 1'b0);
        exp_word(32'h0000_0001, 1'b1);
        run_case("cycle", 16'd0, 1'b0, 1'b0);
`endif

        // Abort a diamond traversal with reset, then rerun it from scratch.
        load_diamond();
        push_diamond();
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_node = 16'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_addr", {36'b0, tbl_addr, edge_addr}, 64'(0));
        chk("midrst_outs", {26'b0, out_valid, out_last, busy, done, error, out_data}, 64'(0));
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
        push_diamond();
        run_case("diamond_post_rst", 16'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
